// File: rtl/prog_counter_pkg.sv
// Shared constants for the programmable counter: terminal-mode encodings and
// count direction.
package prog_counter_pkg;

  localparam logic [1:0] MODE_WRAP    = 2'b00;
  localparam logic [1:0] MODE_SAT     = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Mode 2'b11 is reserved and decodes as wrap.
  function automatic logic is_wrap_mode(input logic [1:0] mode);
    return (mode != MODE_SAT) && (mode != MODE_ONESHOT);
  endfunction

endpackage

// File: rtl/prog_counter_tick_gen.sv
// Prescaler for prog_counter: emits a one-cycle step every prescale+1
// enabled cycles; clear restarts the phase.
module tick_gen #(
  parameter int unsigned PRESCALE_WIDTH = 8
) (
  input  logic                      clock,
  input  logic                      resetN,
  input  logic                      enable,
  input  logic                      clear,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      step
);

  logic [PRESCALE_WIDTH-1:0] prescaler_q, prescaler_d;
  logic                      match;

  assign match = (prescaler_q == prescale);
  assign step  = enable & ~clear & match;

  // A prescale value lowered below the current phase lets the prescaler run on
  // and wrap naturally before the next match.
  always_comb begin
    prescaler_d = prescaler_q;
    if (clear) begin
      prescaler_d = '0;
    end else if (enable) begin
      prescaler_d = match ? '0 : prescaler_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      prescaler_q <= '0;
    end else begin
      prescaler_q <= prescaler_d;
    end
  end

endmodule

// File: rtl/prog_counter.sv
// Up/down counter with run-time limit, load, prescaler and wrap/saturate/
// one-shot terminal behaviour; shared timebase for baud, video and tone timing.
module prog_counter
  import prog_counter_pkg::*;
#(
  parameter int unsigned      WIDTH          = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE    = '0,
  parameter int unsigned      PRESCALE_WIDTH = 8
) (
  input  logic                      clock,
  input  logic                      resetN,
  input  logic                      enable,
  input  logic                      load,
  input  logic [WIDTH-1:0]          load_value,
  input  logic [WIDTH-1:0]          limit,
  input  logic                      up_down,
  input  logic [1:0]                mode,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic [WIDTH-1:0]          count,
  output logic                      tick,
  output logic                      tc,
  output logic                      done
);

  logic             step;
  logic             at_terminal;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tick_q, tick_d;
  logic             tc_q, tc_d;
  logic             done_q, done_d;

  tick_gen #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_tick_gen (
    .clock   (clock),
    .resetN  (resetN),
    .enable  (enable),
    .clear   (load),
    .prescale(prescale),
    .step    (step)
  );

  // Up terminates on >= so a loaded value above limit still terminates.
  assign at_terminal = (up_down == DIR_UP) ? (count_q >= limit) : (count_q == '0);

  always_comb begin
    count_d = count_q;
    done_d  = done_q;
    tick_d  = 1'b0;
    tc_d    = 1'b0;
    if (load) begin
      count_d = load_value;
      done_d  = 1'b0;
    end else if (step) begin
      tick_d = 1'b1;
      if (!done_q) begin
        if (at_terminal) begin
          tc_d = 1'b1;
          if (mode == MODE_ONESHOT) begin
            done_d = 1'b1;
          end else if (is_wrap_mode(mode)) begin
            count_d = (up_down == DIR_UP) ? '0 : limit;
          end
        end else if (up_down == DIR_UP) begin
          count_d = count_q + 1'b1;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      count_q <= RESET_VALUE;
      tick_q  <= 1'b0;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      tick_q  <= tick_d;
      tc_q    <= tc_d;
      done_q  <= done_d;
    end
  end

  assign count = count_q;
  assign tick  = tick_q;
  assign tc    = tc_q;
  assign done  = done_q;

endmodule

// File: tb/tb_prog_counter.sv
// Directed and randomized checks of prog_counter against a behavioural model.
module tb_prog_counter;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned PW    = 8;

  logic             clock = 1'b0;
  logic             resetN;
  logic             enable;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] limit;
  logic             up_down;
  logic [1:0]       mode;
  logic [PW-1:0]    prescale;
  logic [WIDTH-1:0] count;
  logic             tick;
  logic             tc;
  logic             done;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  int m_cnt;
  int m_pre;
  int m_tick;
  int m_tc;
  int m_done;

  int exp1 [6] = '{1, 2, 3, 4, 0, 1};
  int exp3 [4] = '{1, 0, 0, 0};

  prog_counter #(
    .WIDTH         (WIDTH),
    .RESET_VALUE   ('0),
    .PRESCALE_WIDTH(PW)
  ) dut (
    .clock     (clock),
    .resetN    (resetN),
    .enable    (enable),
    .load      (load),
    .load_value(load_value),
    .limit     (limit),
    .up_down   (up_down),
    .mode      (mode),
    .prescale  (prescale),
    .count     (count),
    .tick      (tick),
    .tc        (tc),
    .done      (done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One rising edge of the specified behaviour, in plain integer terms.
  task automatic model_edge();
    int lim;
    lim = int'(limit);
    if (!resetN) begin
      m_cnt = 0; m_pre = 0; m_tick = 0; m_tc = 0; m_done = 0;
    end else if (load) begin
      m_cnt = int'(load_value); m_pre = 0; m_tick = 0; m_tc = 0; m_done = 0;
    end else begin
      m_tick = 0;
      m_tc   = 0;
      if (enable) begin
        if (m_pre == int'(prescale)) begin
          m_pre  = 0;
          m_tick = 1;
          if (m_done == 0) begin
            if (up_down) begin
              if (m_cnt >= lim) begin
                m_tc = 1;
                if (mode == 2'b10) m_done = 1;
                else if (mode != 2'b01) m_cnt = 0;
              end else begin
                m_cnt = m_cnt + 1;
              end
            end else begin
              if (m_cnt == 0) begin
                m_tc = 1;
                if (mode == 2'b10) m_done = 1;
                else if (mode != 2'b01) m_cnt = lim;
              end else begin
                m_cnt = m_cnt - 1;
              end
            end
          end
        end else begin
          m_pre = (m_pre + 1) % (1 << PW);
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    model_edge();
    #1;
    chk("count", 32'(count), 32'(m_cnt));
    chk("tick", 32'(tick), 32'(m_tick));
    chk("tc", 32'(tc), 32'(m_tc));
    chk("done", 32'(done), 32'(m_done));
  endtask

  task automatic do_load(input int value);
    load       = 1'b1;
    load_value = WIDTH'(value);
    cycle();
    load       = 1'b0;
  endtask

  initial begin
    resetN = 1'b0; enable = 1'b1; load = 1'b0; load_value = '0;
    limit = 16'd4; up_down = 1'b1; mode = 2'b00; prescale = '0;
    m_cnt = 0; m_pre = 0; m_tick = 0; m_tc = 0; m_done = 0;

    // Reset state
    cycle();
    cycle();
    chk("reset_count", 32'(count), 32'd0);

    // Up-wrap, limit 4, one step per cycle
    resetN = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("upwrap_count", 32'(count), 32'(exp1[i]));
      chk("upwrap_tc", 32'(tc), 32'(exp1[i] == 0 ? 1 : 0));
      chk("upwrap_tick", 32'(tick), 32'd1);
    end

    // Prescale 2 with an enable gap mid-period
    prescale = 8'd2; limit = 16'd3;
    do_load(0);
    for (int i = 0; i < 9; i++) cycle();
    cycle();
    enable = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    enable = 1'b1;
    for (int i = 0; i < 6; i++) cycle();

    // Down-saturate then down-wrap
    prescale = '0; up_down = 1'b0; mode = 2'b01;
    do_load(2);
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("downsat_count", 32'(count), 32'(exp3[i]));
      chk("downsat_tc", 32'(tc), 32'(i >= 2 ? 1 : 0));
    end
    mode = 2'b00; limit = 16'd5;
    cycle();
    chk("downwrap_count0", 32'(count), 32'd5);
    cycle();
    chk("downwrap_count1", 32'(count), 32'd4);

    // One-shot
    up_down = 1'b1; limit = 16'd3; mode = 2'b10;
    do_load(0);
    for (int i = 0; i < 3; i++) cycle();
    cycle();
    chk("oneshot_done", 32'(done), 32'd1);
    chk("oneshot_tc", 32'(tc), 32'd1);
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("oneshot_hold", 32'(count), 32'd3);
    end
    do_load(1);
    chk("oneshot_reload_done", 32'(done), 32'd0);
    cycle();
    chk("oneshot_resume", 32'(count), 32'd2);

    // Load colliding with a prescaler match
    mode = 2'b00; prescale = 8'd2; limit = 16'd100;
    do_load(0);
    cycle();
    cycle();
    do_load(16'h1234);
    chk("load_override", 32'(count), 32'h1234);
    cycle();
    cycle();

    // Reset beats load; reset mid-count
    resetN = 1'b0; load = 1'b1; load_value = 16'h55;
    cycle();
    chk("reset_over_load", 32'(count), 32'd0);
    resetN = 1'b1; load = 1'b0; prescale = '0;
    for (int i = 0; i < 7; i++) cycle();
    chk("midcount_seven", 32'(count), 32'd7);
    resetN = 1'b0;
    cycle();
    chk("midreset_count", 32'(count), 32'd0);
    chk("midreset_tc", 32'(tc), 32'd0);
    resetN = 1'b1;

    // Loaded value above limit
    limit = 16'd4;
    do_load(9);
    cycle();
    chk("oor_up_count", 32'(count), 32'd0);
    chk("oor_up_tc", 32'(tc), 32'd1);
    up_down = 1'b0;
    do_load(9);
    cycle();
    chk("oor_down0", 32'(count), 32'd8);
    cycle();
    chk("oor_down1", 32'(count), 32'd7);

    // Prescale lowered below the running phase forces a wrap of the prescaler
    up_down = 1'b1; limit = 16'd1000; prescale = 8'd5;
    do_load(0);
    for (int i = 0; i < 3; i++) cycle();
    prescale = 8'd1;
    for (int i = 0; i < 260; i++) cycle();

    // Randomized mix
    for (int i = 0; i < 800; i++) begin
      resetN     = ($urandom_range(63) != 0);
      load       = ($urandom_range(15) == 0);
      load_value = WIDTH'($urandom_range(20));
      enable     = ($urandom_range(3) != 0);
      up_down    = 1'($urandom_range(1));
      mode       = 2'($urandom_range(3));
      if ($urandom_range(7) == 0) limit = WIDTH'($urandom_range(15));
      if ($urandom_range(15) == 0)
        prescale = ($urandom_range(7) == 0) ? PW'($urandom_range(255)) : PW'($urandom_range(2));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
